// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - operation/status bundle between a controller and pc_sequencer
//
// Purpose: carries the per-cycle operation request into the sequencer and the
// registered program counter plus return-stack status back out.
// Signals:
//   EN          - advance enable; when low the sequencer holds all state
//   OP[2:0]     - 000 INC, 001 JMP, 010 BRR, 011 CALL, 100 RET, 101-111 HOLD
//   COND        - branch condition for JMP and BRR
//   TARGET      - absolute address (JMP, CALL) or signed offset (BRR)
//   PC          - registered program counter
//   DEPTH       - number of valid return-stack entries
//   STACK_FULL  - DEPTH == STACK_DEPTH
//   STACK_EMPTY - DEPTH == 0
//   OVF, UNF    - sticky stack overflow / underflow flags
// Modports: master drives the request and observes status; slave is the sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic               EN;
    logic [2:0]         OP;
    logic               COND;
    logic [ADDR_W-1:0]  TARGET;
    logic [ADDR_W-1:0]  PC;
    logic [DEPTH_W-1:0] DEPTH;
    logic               STACK_FULL;
    logic               STACK_EMPTY;
    logic               OVF;
    logic               UNF;

    modport master (
        output EN, OP, COND, TARGET,
        input  PC, DEPTH, STACK_FULL, STACK_EMPTY, OVF, UNF
    );

    modport slave (
        input  EN, OP, COND, TARGET,
        output PC, DEPTH, STACK_FULL, STACK_EMPTY, OVF, UNF
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with return-address stack
//
// Purpose: holds a program counter that increments, jumps, branches relative,
// calls (pushing the return address) and returns (popping it), one operation
// per enabled clock edge.
// Ports:
//   CLK    - clock, all state changes on the rising edge
//   RESET  - asynchronous active-high reset (PC = RESET_ADDR, stack empty, flags clear)
//   seq_if - pc_sequencer_if.slave: EN/OP/COND/TARGET in, PC/DEPTH/status out
module pc_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
    input  logic            CLK,
    input  logic            RESET,
    pc_sequencer_if.slave   seq_if
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_BRR  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] top_entry;
    logic              full;
    logic              empty;

    assign full  = (depth_q == DW'(STACK_DEPTH));
    assign empty = (depth_q == '0);

    always_comb begin
        pc_inc    = pc_q + ADDR_W'(1);
        // Entry i holds the return address pushed when DEPTH went from i to i+1,
        // so the top of stack is entry DEPTH-1.
        top_entry = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) top_entry = stack_q[i];
        end

        pc_d    = pc_q;
        depth_d = depth_q;
        stack_d = stack_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (seq_if.EN) begin
            case (seq_if.OP)
                OP_INC:  pc_d = pc_inc;
                OP_JMP:  pc_d = seq_if.COND ? seq_if.TARGET : pc_inc;
                // Unsigned add of a two's-complement offset wraps to the right result.
                OP_BRR:  pc_d = seq_if.COND ? (pc_q + seq_if.TARGET) : pc_inc;
                OP_CALL: begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        for (int i = 0; i < STACK_DEPTH; i++) begin
                            if (depth_q == DW'(i)) stack_d[i] = pc_inc;
                        end
                        depth_d = depth_q + DW'(1);
                        pc_d    = seq_if.TARGET;
                    end
                end
                OP_RET: begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = top_entry;
                        depth_d = depth_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q    <= RESET_ADDR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset: entries at or above DEPTH are never read.
    always_ff @(posedge CLK) begin
        if (!RESET) stack_q <= stack_d;
    end

    assign seq_if.PC          = pc_q;
    assign seq_if.DEPTH       = depth_q;
    assign seq_if.STACK_FULL  = full;
    assign seq_if.STACK_EMPTY = empty;
    assign seq_if.OVF         = ovf_q;
    assign seq_if.UNF         = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;
    localparam int         AW  = 8;
    localparam int         SD  = 4;
    localparam int         MOD = 1 << AW;
    localparam logic [7:0] RA  = 8'h00;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    pc_sequencer_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) seq_if ();

    pc_sequencer #(.ADDR_W(AW), .STACK_DEPTH(SD), .RESET_ADDR(RA)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .seq_if (seq_if)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: PC as an integer, stack as a queue (back = top).
    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = int'(RA);
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [2:0] op, input bit cond, input int tgt);
        int off;
        if (!en) return;
        case (op)
            3'd0: m_pc = (m_pc + 1) % MOD;
            3'd1: m_pc = cond ? tgt : (m_pc + 1) % MOD;
            3'd2: begin
                off  = (tgt >= MOD / 2) ? tgt - MOD : tgt;
                m_pc = cond ? (m_pc + off + MOD) % MOD : (m_pc + 1) % MOD;
            end
            3'd3: begin
                if (m_stack.size() < SD) begin
                    m_stack.push_back((m_pc + 1) % MOD);
                    m_pc = tgt;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            3'd4: begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else                    m_unf = 1'b1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(seq_if.PC),          32'(m_pc));
        chk({tag, ".depth"}, 32'(seq_if.DEPTH),       32'(m_stack.size()));
        chk({tag, ".full"},  32'(seq_if.STACK_FULL),  32'(m_stack.size() == SD));
        chk({tag, ".empty"}, 32'(seq_if.STACK_EMPTY), 32'(m_stack.size() == 0));
        chk({tag, ".ovf"},   32'(seq_if.OVF),         32'(m_ovf));
        chk({tag, ".unf"},   32'(seq_if.UNF),         32'(m_unf));
    endtask

    task automatic do_op(input bit en, input logic [2:0] op, input bit cond,
                         input logic [7:0] tgt, input string tag);
        seq_if.EN     = en;
        seq_if.OP     = op;
        seq_if.COND   = cond;
        seq_if.TARGET = tgt;
        @(posedge CLK);
        #1;
        model_step(en, op, cond, int'(tgt));
        check_all(tag);
    endtask

    logic [7:0] ret_exp [4];

    initial begin
        RESET         = 1'b1;
        seq_if.EN     = 1'b0;
        seq_if.OP     = 3'd0;
        seq_if.COND   = 1'b0;
        seq_if.TARGET = 8'h00;
        model_reset();
        #3;
        check_all("reset");
        @(negedge CLK);
        RESET = 1'b0;

        // Increment and enable hold
        do_op(1, 3'd0, 0, 8'h00, "inc1"); chk("inc1.val", 32'(seq_if.PC), 32'h01);
        do_op(1, 3'd0, 0, 8'h00, "inc2"); chk("inc2.val", 32'(seq_if.PC), 32'h02);
        do_op(1, 3'd0, 0, 8'h00, "inc3"); chk("inc3.val", 32'(seq_if.PC), 32'h03);
        do_op(0, 3'd3, 1, 8'h55, "en0_a");
        do_op(0, 3'd4, 1, 8'h55, "en0_b"); chk("en0.val", 32'(seq_if.PC), 32'h03);

        // Wrap and relative branch
        do_op(1, 3'd1, 1, 8'hFF, "jmp_ff");
        do_op(1, 3'd0, 0, 8'h00, "wrap");     chk("wrap.val", 32'(seq_if.PC), 32'h00);
        do_op(1, 3'd1, 0, 8'h77, "jmp_nc");   chk("jmp_nc.val", 32'(seq_if.PC), 32'h01);
        do_op(1, 3'd1, 1, 8'h10, "jmp_10");
        do_op(1, 3'd2, 1, 8'hFC, "brr_t");    chk("brr_t.val", 32'(seq_if.PC), 32'h0C);
        do_op(1, 3'd1, 1, 8'h10, "jmp_10b");
        do_op(1, 3'd2, 0, 8'hFC, "brr_nt");   chk("brr_nt.val", 32'(seq_if.PC), 32'h11);
        for (int c = 5; c < 8; c++) do_op(1, 3'(c), 1, 8'hAA, "hold");

        // Nested call/return
        do_op(1, 3'd1, 1, 8'h20, "jmp_20");
        do_op(1, 3'd3, 0, 8'h40, "call40");   chk("call40.val", 32'(seq_if.PC), 32'h40);
        do_op(1, 3'd3, 0, 8'h60, "call60");   chk("call60.d", 32'(seq_if.DEPTH), 32'd2);
        do_op(1, 3'd4, 0, 8'h00, "ret1");     chk("ret1.val", 32'(seq_if.PC), 32'h41);
        do_op(1, 3'd4, 0, 8'h00, "ret2");     chk("ret2.val", 32'(seq_if.PC), 32'h21);

        // Fill, overflow, LIFO drain
        for (int i = 0; i < 4; i++) do_op(1, 3'd3, 0, 8'(8'h80 + 8 * i), "fill");
        chk("fill.full", 32'(seq_if.STACK_FULL), 32'd1);
        do_op(1, 3'd3, 0, 8'hF0, "ovf");
        chk("ovf.pc", 32'(seq_if.PC), 32'h98);
        chk("ovf.flag", 32'(seq_if.OVF), 32'd1);
        ret_exp[0] = 8'h91; ret_exp[1] = 8'h89; ret_exp[2] = 8'h81; ret_exp[3] = 8'h22;
        for (int i = 0; i < 4; i++) begin
            do_op(1, 3'd4, 0, 8'h00, "drain");
            chk("drain.val", 32'(seq_if.PC), 32'(ret_exp[i]));
        end

        // Underflow stickiness
        do_op(1, 3'd4, 0, 8'h00, "unf");
        chk("unf.pc", 32'(seq_if.PC), 32'h22);
        chk("unf.flag", 32'(seq_if.UNF), 32'd1);
        do_op(1, 3'd0, 0, 8'h00, "unf_inc1");
        do_op(1, 3'd0, 0, 8'h00, "unf_inc2");
        chk("unf.sticky", 32'(seq_if.UNF), 32'd1);

        // Asynchronous reset between edges with DEPTH = 2
        do_op(1, 3'd3, 0, 8'h30, "pre_c1");
        do_op(1, 3'd3, 0, 8'h50, "pre_c2");
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.pc", 32'(seq_if.PC), 32'(RA));
        seq_if.EN = 1'b1; seq_if.OP = 3'd3; seq_if.TARGET = 8'h77;
        @(posedge CLK);
        #1;
        check_all("rst_hold");
        @(negedge CLK);
        RESET = 1'b0;
        do_op(1, 3'd4, 0, 8'h00, "post_rst_ret");
        chk("post_rst.unf", 32'(seq_if.UNF), 32'd1);

        // Randomized operation stream with occasional asynchronous resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                RESET = 1'b1;
                #2;
                RESET = 1'b0;
                model_reset();
                check_all("rnd_rst");
            end else begin
                do_op(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 8'($urandom), "rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the PC and TARGET width in bits (ADDR_W >= 2).
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the number of return-address stack entries (STACK_DEPTH >= 1).
REQ-003 Parameter RESET_ADDR, default 0, SHALL set the PC value loaded on reset (ADDR_W bits).
REQ-004 Port CLK, input, 1 bit, SHALL be the clock; all state updates occur on its rising edge.
REQ-005 Port RESET, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-006 Port EN, input, 1 bit, SHALL be the synchronous advance enable.
REQ-007 Port OP, input, 3 bits, SHALL select the operation: 000 INC, 001 JMP, 010 BRR, 011 CALL, 100 RET, 101-111 HOLD.
REQ-008 Port COND, input, 1 bit, SHALL be the branch condition for JMP and BRR.
REQ-009 Port TARGET, input, ADDR_W bits, SHALL carry the absolute address (JMP, CALL) or the two's-complement offset (BRR).
REQ-010 Port PC, output, ADDR_W bits, SHALL be the registered current program counter.
REQ-011 Port DEPTH, output, clog2(STACK_DEPTH+1) bits, SHALL give the number of valid stack entries.
REQ-012 Port STACK_FULL and port STACK_EMPTY, outputs, 1 bit each, SHALL be combinational decodes of DEPTH == STACK_DEPTH and DEPTH == 0.
REQ-013 Port OVF and port UNF, outputs, 1 bit each, SHALL be the sticky stack overflow and underflow flags.

Function
REQ-014 With EN=0, PC, stack contents, DEPTH, OVF and UNF SHALL hold, regardless of OP.
REQ-015 INC with EN=1 SHALL set PC <= PC+1, modulo 2^ADDR_W (all-ones wraps to 0).
REQ-016 JMP with EN=1 SHALL set PC <= TARGET if COND=1, else PC+1.
REQ-017 BRR with EN=1 SHALL set PC <= PC+TARGET if COND=1, else PC+1:
- TARGET sign-interpreted
- result modulo 2^ADDR_W, no overflow flagging.
REQ-018 CALL with EN=1 and DEPTH < STACK_DEPTH SHALL:
- push PC+1 (wrapped) onto the stack top
- increment DEPTH
- set PC <= TARGET.
REQ-019 CALL with EN=1 and DEPTH == STACK_DEPTH SHALL:
- leave PC, stack and DEPTH unchanged
- set OVF=1.
REQ-020 RET with EN=1 and DEPTH > 0 SHALL set PC <= top entry and decrement DEPTH (LIFO order).
REQ-021 RET with EN=1 and DEPTH == 0 SHALL leave PC and DEPTH unchanged and set UNF=1.
REQ-022 HOLD codes with EN=1 SHALL leave all state unchanged.
REQ-023 Each operation SHALL take effect at the first rising CLK edge where it is sampled with EN=1, giving one-cycle latency with no bubbles, so back-to-back CALL/RET on consecutive cycles is legal.
REQ-024 OVF and UNF SHALL stay set until RESET and SHALL NOT block further operations.
REQ-025 Stack entries at or above DEPTH SHALL have no observable effect.

Reset
REQ-026 RESET=1 SHALL immediately, without a clock edge, force:
- PC = RESET_ADDR
- DEPTH = 0
- STACK_EMPTY = 1, STACK_FULL = 0
- OVF = 0, UNF = 0.
REQ-027 While RESET=1, CLK edges and all inputs SHALL be ignored; assertion mid-operation SHALL discard any operation in progress.
REQ-028 After RESET deasserts, the first rising CLK edge SHALL process inputs normally.

Verification
REQ-029 Reset, then INC x3 with EN=1 -> PC = 1, 2, 3; EN=0 for 2 cycles -> PC stays 3.
REQ-030 PC = 0xFF, INC -> PC = 0x00; PC = 0x10, BRR with COND=1 and TARGET = 0xFC -> PC = 0x0C; same with COND=0 -> PC = 0x11.
REQ-031 From PC = 0x20, CALL 0x40, CALL 0x60, RET, RET -> PC = 0x40, 0x60, 0x41, 0x21; DEPTH = 1, 2, 1, 0.
REQ-032 Four CALLs fill the stack (STACK_FULL = 1); a fifth CALL -> PC and DEPTH unchanged, OVF = 1; four RETs return the addresses in LIFO order.
REQ-033 RET with DEPTH = 0 -> PC unchanged, UNF = 1; UNF persists across later INCs and clears only on RESET.
REQ-034 Assert RESET asynchronously between edges with DEPTH = 2 -> PC = RESET_ADDR and DEPTH = 0 before the next edge; the first post-reset RET -> UNF = 1.
